// File: rtl/zeroriscy_mem_arbiter_if.sv
// One request/response memory port: a master-side request channel plus its
// in-order response channel.
interface zeroriscy_mem_arbiter_if #(
  parameter int AW = 32
);
  // Handshake: the request is accepted in a cycle with req && gnt both high.
  // The master holds req and its fields stable until gnt arrives. Each
  // accepted request gets exactly one rvalid pulse, one or more cycles later,
  // in acceptance order. rdata and err are meaningful only while rvalid is high.
  logic          req;
  logic          we;
  logic [3:0]    be;
  logic [AW-1:0] addr;
  logic [31:0]   wdata;
  logic          gnt;
  logic          rvalid;
  logic          err;
  logic [31:0]   rdata;

  modport master (
    output req, we, be, addr, wdata,
    input  gnt, rvalid, err, rdata
  );

  modport slave (
    input  req, we, be, addr, wdata,
    output gnt, rvalid, err, rdata
  );
endinterface

// File: rtl/zeroriscy_mem_arbiter.sv
// Round-robin arbiter that merges instruction and data masters onto one memory
// port. Each response is steered to its owner through an in-order owner FIFO.
module zeroriscy_mem_arbiter #(
  parameter int MAX_OUTSTANDING = 2,
  parameter int AW              = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  zeroriscy_mem_arbiter_if.slave  m0,
  zeroriscy_mem_arbiter_if.slave  m1,
  zeroriscy_mem_arbiter_if.master s,
  output logic                    proto_err,
  output logic [2:0]              o_dbg_occupancy,
  output logic                    o_dbg_rr_last
);

  localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam logic [PW-1:0] LAST_PTR = PW'(MAX_OUTSTANDING - 1);
  localparam logic [2:0]    FULL_CNT = 3'(MAX_OUTSTANDING);

  logic          r_owner [MAX_OUTSTANDING];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [2:0]    r_count;
  logic          r_rr_last;
  logic          r_proto_err;

  logic          w_any_req;
  logic          w_sel;
  logic          w_full;
  logic          w_empty;
  logic          w_can_issue;
  logic          w_s_req;
  logic          w_accept;
  logic          w_pop;
  logic          w_head;
  logic [AW-1:0] w_addr;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  // A full FIFO may still issue when a response frees a slot this same cycle.
  always_comb begin
    w_any_req = m0.req | m1.req;
    w_sel     = 1'b0;
    if (m0.req && m1.req) begin
      w_sel = ~r_rr_last;
    end else if (m1.req) begin
      w_sel = 1'b1;
    end
    w_full      = (r_count == FULL_CNT);
    w_empty     = (r_count == 3'd0);
    w_can_issue = !w_full || s.rvalid;
    w_s_req     = rst_n && w_any_req && w_can_issue;
    w_accept    = w_s_req && s.gnt;
    w_pop       = rst_n && s.rvalid && !w_empty;
    w_head      = r_owner[r_rd_ptr];
  end

  always_comb begin
    s.we    = 1'b0;
    s.be    = 4'b0000;
    w_addr  = '0;
    s.wdata = 32'd0;
    if (w_any_req) begin
      if (w_sel) begin
        s.we    = m1.we;
        s.be    = m1.be;
        w_addr  = m1.addr;
        s.wdata = m1.wdata;
      end else begin
        s.we    = m0.we;
        s.be    = m0.be;
        w_addr  = m0.addr;
        s.wdata = m0.wdata;
      end
    end
  end

  assign s.addr    = w_addr;
  assign s.req     = w_s_req;
  assign m0.gnt    = w_accept && !w_sel;
  assign m1.gnt    = w_accept && w_sel;
  assign m0.rvalid = w_pop && !w_head;
  assign m1.rvalid = w_pop && w_head;
  assign m0.err    = w_pop && !w_head && s.err;
  assign m1.err    = w_pop && w_head && s.err;
  assign m0.rdata  = s.rdata;
  assign m1.rdata  = s.rdata;

  assign proto_err       = r_proto_err;
  assign o_dbg_occupancy = r_count;
  assign o_dbg_rr_last   = r_rr_last;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= 3'd0;
      r_rr_last   <= 1'b1;
      r_proto_err <= 1'b0;
    end else begin
      if (w_accept) begin
        r_wr_ptr  <= ptr_next(r_wr_ptr);
        r_rr_last <= w_sel;
      end
      if (w_pop) begin
        r_rd_ptr <= ptr_next(r_rd_ptr);
      end
      if (w_accept && !w_pop) begin
        r_count <= r_count + 3'd1;
      end else if (!w_accept && w_pop) begin
        r_count <= r_count - 3'd1;
      end
      if (s.rvalid && w_empty) begin
        r_proto_err <= 1'b1;
      end
    end
  end

  // Owner IDs need no reset: occupancy decides which entries are live.
  always_ff @(posedge clk) begin
    if (rst_n && w_accept) begin
      r_owner[r_wr_ptr] <= w_sel;
    end
  end

endmodule

// File: tb/tb_zeroriscy_mem_arbiter.sv
// Directed bench for zeroriscy_mem_arbiter: a memory model answers accepted
// requests, and a monitor checks grants and responses against expected queues.
module tb_zeroriscy_mem_arbiter;

  logic       clk;
  logic       rst_n;
  logic       proto_err;
  logic [2:0] dbg_occ;
  logic       dbg_rr_last;

  zeroriscy_mem_arbiter_if #(.AW(32)) m0_bus ();
  zeroriscy_mem_arbiter_if #(.AW(32)) m1_bus ();
  zeroriscy_mem_arbiter_if #(.AW(32)) s_bus ();

  zeroriscy_mem_arbiter #(.MAX_OUTSTANDING(2), .AW(32)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .m0              (m0_bus.slave),
    .m1              (m1_bus.slave),
    .s               (s_bus.master),
    .proto_err       (proto_err),
    .o_dbg_occupancy (dbg_occ),
    .o_dbg_rr_last   (dbg_rr_last)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // scoreboard state
  int          n_vec  = 0;
  int          n_fail = 0;
  logic [33:0] exp_q[$];      // {owner id, err, rdata}
  logic [0:0]  exp_gnt_q[$];  // granted master id
  logic [31:0] pend_q[$];     // addresses awaiting a memory response
  logic        mem_hold   = 1'b0;
  int          inject_cnt  = 0;
  int          inject_done = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  task automatic drive_m0(input logic req, input logic we, input logic [3:0] be,
                          input logic [31:0] addr, input logic [31:0] wdata);
    m0_bus.req = req; m0_bus.we = we; m0_bus.be = be;
    m0_bus.addr = addr; m0_bus.wdata = wdata;
  endtask

  task automatic drive_m1(input logic req, input logic we, input logic [3:0] be,
                          input logic [31:0] addr, input logic [31:0] wdata);
    m1_bus.req = req; m1_bus.we = we; m1_bus.be = be;
    m1_bus.addr = addr; m1_bus.wdata = wdata;
  endtask

  task automatic idle_both();
    drive_m0(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    drive_m1(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || exp_gnt_q.size() != 0) && n < 20) begin
      step();
      n++;
    end
    check(name, 64'(exp_q.size() + exp_gnt_q.size()), 64'd0);
  endtask

  // Memory model: rdata = {16'hA5A5, addr[15:0]}, err = addr[12], one cycle later.
  always begin
    logic [31:0] a;
    @(negedge clk);
    if (!rst_n) pend_q.delete();
    else if (s_bus.req && s_bus.gnt) pend_q.push_back(s_bus.addr);
    @(posedge clk);
    #2;
    if (!rst_n) begin
      s_bus.rvalid = 1'b0; s_bus.err = 1'b0; s_bus.rdata = 32'h0;
    end else if (inject_cnt != inject_done) begin
      s_bus.rvalid = 1'b1; s_bus.err = 1'b0; s_bus.rdata = 32'h0BAD_0BAD;
      inject_done++;
    end else if (!mem_hold && pend_q.size() != 0) begin
      a = pend_q.pop_front();
      s_bus.rvalid = 1'b1; s_bus.err = a[12]; s_bus.rdata = {16'hA5A5, a[15:0]};
    end else begin
      s_bus.rvalid = 1'b0; s_bus.err = 1'b0; s_bus.rdata = 32'h0;
    end
  end

  // monitor
  always @(negedge clk) begin
    logic [33:0] e;
    logic [0:0]  g;
    if (m0_bus.gnt || m1_bus.gnt) begin
      if (m0_bus.gnt && m1_bus.gnt) check("dual_gnt", 64'd1, 64'd0);
      else if (exp_gnt_q.size() == 0) check("gnt_unexpected", 64'd1, 64'd0);
      else begin
        g = exp_gnt_q.pop_front();
        check("gnt_id", 64'(m1_bus.gnt), 64'(g));
      end
    end
    if (m0_bus.rvalid || m1_bus.rvalid) begin
      if (m0_bus.rvalid && m1_bus.rvalid) check("dual_rvalid", 64'd1, 64'd0);
      else if (exp_q.size() == 0) check("rvalid_unexpected", 64'd1, 64'd0);
      else begin
        e = exp_q.pop_front();
        check("resp_id_err_rdata",
              64'({m1_bus.rvalid, (m1_bus.rvalid ? m1_bus.err : m0_bus.err), m0_bus.rdata}),
              64'(e));
        check("resp_m1_rdata", 64'(m1_bus.rdata), 64'(e[31:0]));
      end
    end
  end

  // directed stimulus
  initial begin
    rst_n = 1'b0;
    idle_both();
    s_bus.gnt = 1'b1;
    s_bus.rvalid = 1'b0; s_bus.err = 1'b0; s_bus.rdata = 32'h0;
    repeat (3) step();

    at_neg();
    check("rst_s_req", 64'(s_bus.req), 64'd0);
    check("rst_occ", 64'(dbg_occ), 64'd0);
    check("rst_rr_last", 64'(dbg_rr_last), 64'd1);
    check("rst_proto_err", 64'(proto_err), 64'd0);

    // back-to-back ties alternate m0, m1, m0, m1
    step();
    rst_n = 1'b1;
    exp_gnt_q.push_back(1'b0); exp_gnt_q.push_back(1'b1);
    exp_gnt_q.push_back(1'b0); exp_gnt_q.push_back(1'b1);
    exp_q.push_back({1'b0, 1'b0, 32'hA5A5_0010}); exp_q.push_back({1'b1, 1'b0, 32'hA5A5_0020});
    exp_q.push_back({1'b0, 1'b0, 32'hA5A5_0010}); exp_q.push_back({1'b1, 1'b0, 32'hA5A5_0020});
    drive_m0(1'b1, 1'b0, 4'hF, 32'h10, 32'h0);
    drive_m1(1'b1, 1'b0, 4'hF, 32'h20, 32'h0);
    at_neg();
    check("t1_first_addr", 64'(s_bus.addr), 64'h10);
    repeat (4) step();
    idle_both();
    at_neg();
    check("idle_addr", 64'(s_bus.addr), 64'h0);
    check("idle_be_we", 64'({s_bus.we, s_bus.be}), 64'h0);
    drain("t1_drain");

    // full FIFO stalls the port until a response frees a slot
    mem_hold = 1'b1;
    exp_gnt_q.push_back(1'b0); exp_gnt_q.push_back(1'b1); exp_gnt_q.push_back(1'b0);
    exp_q.push_back({1'b0, 1'b0, 32'hA5A5_0030}); exp_q.push_back({1'b1, 1'b0, 32'hA5A5_0040});
    exp_q.push_back({1'b0, 1'b0, 32'hA5A5_0030});
    drive_m0(1'b1, 1'b0, 4'hF, 32'h30, 32'h0);
    drive_m1(1'b1, 1'b0, 4'hF, 32'h40, 32'h0);
    step();
    step();
    at_neg();
    check("t2_full_s_req", 64'(s_bus.req), 64'd0);
    check("t2_full_occ", 64'(dbg_occ), 64'd2);
    check("t2_full_gnt", 64'({m0_bus.gnt, m1_bus.gnt}), 64'd0);
    step();
    at_neg();
    check("t2_full_s_req2", 64'(s_bus.req), 64'd0);
    step();
    mem_hold = 1'b0;
    at_neg();
    check("t2_reissue_s_req", 64'(s_bus.req), 64'd1);
    check("t2_reissue_m0_gnt", 64'(m0_bus.gnt), 64'd1);
    step();
    idle_both();
    drain("t2_drain");

    // m1 write fields pass through; then an m0 read that errors
    exp_gnt_q.push_back(1'b1);
    exp_q.push_back({1'b1, 1'b0, 32'hA5A5_0100});
    drive_m1(1'b1, 1'b1, 4'b0011, 32'h100, 32'hDEADBEEF);
    at_neg();
    check("t3_we", 64'(s_bus.we), 64'd1);
    check("t3_be", 64'(s_bus.be), 64'h3);
    check("t3_addr", 64'(s_bus.addr), 64'h100);
    check("t3_wdata", 64'(s_bus.wdata), 64'hDEADBEEF);
    check("t3_m1_gnt", 64'(m1_bus.gnt), 64'd1);
    step();
    idle_both();
    at_neg();
    check("t3_rvalid_pair", 64'({m0_bus.rvalid, m1_bus.rvalid}), 64'b01);
    step();
    exp_gnt_q.push_back(1'b0);
    exp_q.push_back({1'b0, 1'b1, 32'hA5A5_1000});
    drive_m0(1'b1, 1'b0, 4'hF, 32'h1000, 32'h0);
    step();
    idle_both();
    at_neg();
    check("t3_m0_err", 64'({m0_bus.err, m1_bus.err}), 64'b10);
    drain("t3_drain");

    // stalled grant: no rotation, m1 wins the tie once s_gnt rises
    s_bus.gnt = 1'b0;
    drive_m0(1'b1, 1'b0, 4'hF, 32'h70, 32'h0);
    drive_m1(1'b1, 1'b0, 4'hF, 32'h80, 32'h0);
    for (int i = 0; i < 3; i++) begin
      at_neg();
      check("t4_stall_gnt", 64'({m0_bus.gnt, m1_bus.gnt}), 64'd0);
      check("t4_stall_s_req", 64'(s_bus.req), 64'd1);
      check("t4_stall_rr_last", 64'(dbg_rr_last), 64'd0);
      step();
    end
    s_bus.gnt = 1'b1;
    exp_gnt_q.push_back(1'b1);
    exp_q.push_back({1'b1, 1'b0, 32'hA5A5_0080});
    at_neg();
    check("t4_resume_m1_gnt", 64'(m1_bus.gnt), 64'd1);
    step();
    idle_both();
    drain("t4_drain");
    check("t4_no_proto_err", 64'(proto_err), 64'd0);

    // stray response with nothing outstanding
    inject_cnt++;
    at_neg();
    check("t5_no_rvalid", 64'({m0_bus.rvalid, m1_bus.rvalid}), 64'd0);
    step();
    at_neg();
    check("t5_proto_err_set", 64'(proto_err), 64'd1);
    repeat (3) step();
    at_neg();
    check("t5_proto_err_sticky", 64'(proto_err), 64'd1);

    // reset with two outstanding discards them; m0 wins the next tie
    step();
    mem_hold = 1'b1;
    exp_gnt_q.push_back(1'b0); exp_gnt_q.push_back(1'b1);
    drive_m0(1'b1, 1'b0, 4'hF, 32'h50, 32'h0);
    drive_m1(1'b1, 1'b0, 4'hF, 32'h60, 32'h0);
    step();
    step();
    at_neg();
    check("t6_occ_before", 64'(dbg_occ), 64'd2);
    step();
    rst_n = 1'b0;
    mem_hold = 1'b0;
    at_neg();
    check("t6_rst_s_req", 64'(s_bus.req), 64'd0);
    check("t6_rst_gnt", 64'({m0_bus.gnt, m1_bus.gnt}), 64'd0);
    check("t6_rst_rvalid", 64'({m0_bus.rvalid, m1_bus.rvalid}), 64'd0);
    step();
    at_neg();
    check("t6_rst_occ", 64'(dbg_occ), 64'd0);
    check("t6_rst_proto_err", 64'(proto_err), 64'd0);
    check("t6_rst_rr_last", 64'(dbg_rr_last), 64'd1);
    step();
    rst_n = 1'b1;
    exp_gnt_q.push_back(1'b0);
    exp_q.push_back({1'b0, 1'b0, 32'hA5A5_0050});
    at_neg();
    check("t6_after_m0_gnt", 64'(m0_bus.gnt), 64'd1);
    step();
    idle_both();
    drain("t6_drain");

    // stray response in the first cycle after reset release
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    inject_cnt++;
    at_neg();
    check("t7_no_rvalid", 64'({m0_bus.rvalid, m1_bus.rvalid}), 64'd0);
    step();
    at_neg();
    check("t7_proto_err", 64'(proto_err), 64'd1);

    // final report
    check("final_exp_q_empty", 64'(exp_q.size()), 64'd0);
    check("final_gnt_q_empty", 64'(exp_gnt_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/zeroriscy_mem_arbiter.md
ZERORISCY_MEM_ARBITER -- requirements
Module: zeroriscy_mem_arbiter

Interface
REQ-001 Parameter MAX_OUTSTANDING, default 2: maximum accepted, unanswered slave transactions (1..4).
REQ-002 Parameter AW, default 32: address width.
REQ-003 Port clk  input  1: single clock; all state updates on posedge clk.
REQ-004 Port rst_n  input  1: reset; synchronous, active-low.
REQ-005 Ports m0_req/m0_we  input  1/1; m0_be  input  4; m0_addr  input  AW; m0_wdata  input  32: master 0 request (instruction side).
REQ-006 Ports m0_gnt/m0_rvalid/m0_err  output  1/1/1; m0_rdata  output  32: master 0 grant and response.
REQ-007 Ports m1_*: identical set to m0_*: master 1 (data side).
REQ-008 Ports s_req/s_we  output  1/1; s_be  output  4; s_addr  output  AW; s_wdata  output  32: request to the shared memory port.
REQ-009 Ports s_gnt/s_rvalid/s_err  input  1/1/1; s_rdata  input  32: shared memory grant and response.
REQ-010 Port proto_err  output  1: sticky flag, s_rvalid received with no outstanding transaction.

Function
REQ-011 Protocol on all ports: request accepted in a cycle where req and gnt are both high; exactly one rvalid per accepted request, one or more cycles later, in acceptance order.
REQ-012 Arbiter state: rr_last (1 bit, last master granted), an owner FIFO of depth MAX_OUTSTANDING holding the master ID of each accepted transaction, and an occupancy count.
REQ-013 Selection, combinational: only one master requesting -> that master; both requesting -> the master not equal to rr_last; neither -> none.
REQ-014 s_req = (m0_req or m1_req) and can_issue; can_issue = FIFO not full, or FIFO full and s_rvalid high this cycle.
REQ-015 s_we/s_be/s_addr/s_wdata = fields of the selected master; all zero when no master is selected.
REQ-016 mX_gnt = s_gnt and s_req and (selected == X); the unselected master sees gnt low; at most one mX_gnt high per cycle.
REQ-017 On acceptance (s_req and s_gnt): push selected ID into the FIFO; rr_last <= selected ID.
REQ-018 rr_last is unchanged in any cycle without acceptance; a stalled request causes no rotation.
REQ-019 On s_rvalid with FIFO non-empty: pop head; mH_rvalid = 1 and mH_err = s_err for head owner H; other master rvalid/err = 0.
REQ-020 m0_rdata and m1_rdata both equal s_rdata every cycle; only rvalid qualifies the data.
REQ-021 Response latency through the block: zero cycles (s_rvalid to mX_rvalid combinational); grant path combinational.
REQ-022 Simultaneous push and pop: both take effect; occupancy unchanged; allowed at full (REQ-014).
REQ-023 FIFO pointers wrap modulo MAX_OUTSTANDING; occupancy never exceeds MAX_OUTSTANDING nor falls below 0.
REQ-024 s_rvalid with FIFO empty: no pop, both mX_rvalid = 0, proto_err <= 1 (held until reset).
REQ-025 A master that drops req while not granted is legal; selection re-evaluates every cycle.
REQ-026 With continuous requests from both masters and s_gnt = 1, grants alternate m0/m1 every cycle, limited only by REQ-014.

Reset
REQ-027 While rst_n = 0 at posedge clk: FIFO emptied, occupancy = 0, rr_last = 1 (m0 wins first tie), proto_err = 0.
REQ-028 While rst_n = 0: s_req, m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_err, m1_err forced to 0 combinationally.
REQ-029 Reset mid-operation discards outstanding transactions; s_rvalid in the first cycle after reset release sets proto_err.

Verification
REQ-030 After reset, m0_req = m1_req = 1 for 4 cycles, s_gnt = 1, 1-cycle memory -> grants m0,m1,m0,m1; rvalids in the same order, one cycle later each.
REQ-031 MAX_OUTSTANDING = 2, s_gnt = 1, memory withholds s_rvalid -> two acceptances, then s_req = 0 with both masters requesting; first s_rvalid re-enables s_req in that same cycle.
REQ-032 m1 write, be = 4'b0011, addr 0x100, wdata 0xDEADBEEF -> s_we = 1, s_be = 4'b0011, s_addr = 0x100, s_wdata = 0xDEADBEEF; m1_rvalid one cycle later, m0_rvalid = 0.
REQ-033 s_gnt = 0 for 3 cycles with both requesting -> no mX_gnt, rr_last unchanged; the same master is granted when s_gnt rises.
REQ-034 s_rvalid pulsed with FIFO empty -> no mX_rvalid, proto_err = 1 until rst_n = 0.
REQ-035 Assert rst_n = 0 with 2 outstanding -> all outputs 0 next cycle, occupancy 0; next tie after release grants m0.
